// File: rtl/xbar_arb_pkg.sv
// Shared types and sizing helpers for the crossbar arbitration blocks.
package xbar_arb_pkg;

    // Packet-lock state of one output-port arbiter.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Width of a requester index for a port with n requesters.
    function automatic int unsigned idx_w(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/priority_rotate.sv
// Combinational move-to-tail of one entry in a priority permutation.
module priority_rotate
    import xbar_arb_pkg::*;
#(
    parameter int unsigned candidate = 2,
    localparam int unsigned IDX_W = idx_w(candidate)
) (
    input  logic [candidate-1:0][IDX_W-1:0] array_in,
    input  logic [IDX_W-1:0]                g,
    output logic [candidate-1:0][IDX_W-1:0] array_next
);

    logic found;

    // Entries behind g slide up by one; g lands on the tail.
    always_comb begin
        array_next = array_in;
        found      = (array_in[0] == g);
        for (int i = 1; i < int'(candidate); i++) begin
            if (found) begin
                array_next[i-1] = array_in[i];
            end
            if (array_in[i] == g) begin
                found = 1'b1;
            end
        end
        if (found) begin
            array_next[candidate-1] = g;
        end
    end

endmodule

// File: rtl/rr_priority_manager.sv
// Least-recently-granted priority order plus multi-beat packet lock for one output port.
module rr_priority_manager
    import xbar_arb_pkg::*;
#(
    parameter int unsigned candidate = 2,
    localparam int unsigned IDX_W = idx_w(candidate)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [candidate-1:0]            request_vec,
    input  logic [IDX_W-1:0]                grant_number,
    input  logic                            grant_fire,
    input  logic                            grant_last,
    output logic [candidate-1:0][IDX_W-1:0] priority_array,
    output logic                            grant_valid,
    output logic [IDX_W-1:0]                eff_grant,
    output logic                            locked
);

    arb_state_e                     state_q, state_d;
    logic [IDX_W-1:0]               lock_num_q, lock_num_d;
    logic                           rot_en;
    logic [candidate-1:0][IDX_W-1:0] rot_next;

    priority_rotate #(.candidate(candidate)) u_rotate (
        .array_in   (priority_array),
        .g          (eff_grant),
        .array_next (rot_next)
    );

    // State, lock owner and priority order registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lock_num_q <= '0;
            for (int i = 0; i < int'(candidate); i++) begin
                priority_array[i] <= IDX_W'(i);
            end
        end else begin
            state_q    <= state_d;
            lock_num_q <= lock_num_d;
            if (rot_en) begin
                priority_array <= rot_next;
            end
        end
    end

    // Next state, lock capture and effective-grant muxing; requests are masked in reset.
    always_comb begin
        state_d     = state_q;
        lock_num_d  = lock_num_q;
        rot_en      = 1'b0;
        grant_valid = 1'b0;
        eff_grant   = '0;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    grant_valid = |request_vec;
                    eff_grant   = grant_number;
                    if (grant_fire && grant_valid) begin
                        if (grant_last) begin
                            rot_en = 1'b1;
                        end else begin
                            lock_num_d = grant_number;
                            state_d    = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    grant_valid = request_vec[lock_num_q];
                    eff_grant   = lock_num_q;
                    if (grant_fire && grant_valid && grant_last) begin
                        rot_en  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_rr_priority_manager.sv
// Randomised and directed bench for rr_priority_manager with a behavioural generator and LRU model.
module tb_rr_priority_manager;

    localparam int unsigned N = 4;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     request_vec;
    logic [1:0]       grant_number;
    logic             grant_fire;
    logic             grant_last;
    logic [N-1:0][1:0] priority_array;
    logic             grant_valid;
    logic [1:0]       eff_grant;
    logic             locked;

    int checks;
    int errors;

    // Reference model: order as a queue of requester ids, head = highest priority.
    int   m_order[$];
    bit   m_locked;
    int   m_lock;
    logic exp_gv;
    logic [1:0] exp_eff;

    rr_priority_manager #(.candidate(N)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .request_vec    (request_vec),
        .grant_number   (grant_number),
        .grant_fire     (grant_fire),
        .grant_last     (grant_last),
        .priority_array (priority_array),
        .grant_valid    (grant_valid),
        .eff_grant      (eff_grant),
        .locked         (locked)
    );

    always #5 clk = ~clk;

    // Stand-in for grant_number_generator: first requester in the published order.
    always_comb begin
        grant_number = 2'd0;
        for (int k = N - 1; k >= 0; k--) begin
            if (request_vec[priority_array[k]]) grant_number = priority_array[k];
        end
    end

    // Firing without a valid grant must never happen.
    always @(posedge clk) begin
        if (rst_n && grant_fire) begin
            checks++;
            if (!grant_valid) begin
                errors++;
                $display("FAIL fire_without_valid: grant_valid=%0b required 1 at %0t", grant_valid, $time);
            end
        end
    end

    function automatic logic [N-1:0][1:0] model_packed();
        logic [N-1:0][1:0] p;
        for (int i = 0; i < int'(N); i++) p[i] = 2'(m_order[i]);
        return p;
    endfunction

    function automatic void model_reset();
        m_order  = {0, 1, 2, 3};
        m_locked = 0;
        m_lock   = 0;
    endfunction

    function automatic void model_rotate(input int g);
        for (int i = 0; i < m_order.size(); i++) begin
            if (m_order[i] == g) begin
                m_order.delete(i);
                break;
            end
        end
        m_order.push_back(g);
    endfunction

    function automatic void model_expect();
        if (m_locked) begin
            exp_gv  = request_vec[m_lock];
            exp_eff = 2'(m_lock);
        end else begin
            exp_gv  = |request_vec;
            exp_eff = 2'd0;
            for (int i = m_order.size() - 1; i >= 0; i--) begin
                if (request_vec[m_order[i]]) exp_eff = 2'(m_order[i]);
            end
        end
    endfunction

    // Apply inputs mid-cycle and settle expectations.
    task automatic drive(input logic [N-1:0] r, input logic f, input logic l);
        @(negedge clk);
        request_vec = r;
        grant_fire  = f;
        grant_last  = l;
        #1;
        model_expect();
    endtask

    // Clock edge: commit the model update for the inputs currently applied.
    task automatic advance();
        @(posedge clk);
        if (grant_fire && exp_gv) begin
            if (!m_locked) begin
                if (grant_last) model_rotate(int'(exp_eff));
                else begin
                    m_locked = 1;
                    m_lock   = int'(exp_eff);
                end
            end else if (grant_last) begin
                model_rotate(m_lock);
                m_locked = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        logic [N-1:0][1:0] exp_p;
        exp_p = {2'd3, 2'd2, 2'd1, 2'd0};
        rst_n = 0;
        request_vec = 4'hF;
        grant_fire = 0;
        grant_last = 0;
        model_reset();
        #12;
        checks++;
        if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_gv_masked: got %0b required 0", grant_valid); end
        checks++;
        if (eff_grant !== 2'd0) begin errors++; $display("FAIL reset_eff: got %0d required 0", eff_grant); end
        request_vec = 4'h0;
        @(negedge clk);
        rst_n = 1;
        #1;
        checks++;
        if (priority_array !== exp_p) begin errors++; $display("FAIL reset_prio: got %h required %h", priority_array, exp_p); end
        checks++;
        if (grant_valid !== 1'b0 || locked !== 1'b0) begin
            errors++; $display("FAIL reset_flags: gv=%0b locked=%0b required 0 0", grant_valid, locked);
        end
    endtask

    task automatic test_rotate();
        logic [N-1:0][1:0] exp_p;
        drive(4'b0101, 1, 1);
        checks++;
        if (eff_grant !== 2'd0 || grant_valid !== 1'b1) begin
            errors++; $display("FAIL rotate1_eff: eff=%0d gv=%0b required 0 1", eff_grant, grant_valid);
        end
        advance();
        exp_p = {2'd0, 2'd3, 2'd2, 2'd1};
        checks++;
        if (priority_array !== exp_p) begin errors++; $display("FAIL rotate1_prio: got %h required %h", priority_array, exp_p); end
        drive(4'b0101, 1, 1);
        checks++;
        if (eff_grant !== 2'd2) begin errors++; $display("FAIL rotate2_eff: got %0d required 2", eff_grant); end
        advance();
        exp_p = {2'd2, 2'd0, 2'd3, 2'd1};
        checks++;
        if (priority_array !== exp_p) begin errors++; $display("FAIL rotate2_prio: got %h required %h", priority_array, exp_p); end
    endtask

    task automatic test_lock();
        logic [N-1:0][1:0] exp_p;
        exp_p = {2'd2, 2'd0, 2'd3, 2'd1};
        drive(4'b0100, 1, 0);
        checks++;
        if (eff_grant !== 2'd2) begin errors++; $display("FAIL lock_start_eff: got %0d required 2", eff_grant); end
        advance();
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL lock_enter: locked=%0b required 1", locked); end
        for (int b = 0; b < 2; b++) begin
            drive(4'b0110, 1, 0);
            advance();
            checks++;
            if (eff_grant !== 2'd2 || locked !== 1'b1 || priority_array !== exp_p) begin
                errors++;
                $display("FAIL lock_beat: eff=%0d locked=%0b prio=%h required 2 1 %h", eff_grant, locked, priority_array, exp_p);
            end
        end
        drive(4'b0110, 1, 1);
        advance();
        checks++;
        if (locked !== 1'b0 || priority_array !== model_packed()) begin
            errors++; $display("FAIL lock_release: locked=%0b prio=%h required 0 %h", locked, priority_array, model_packed());
        end
    endtask

    task automatic test_drop();
        logic [N-1:0][1:0] exp_p;
        drive(4'b0001, 1, 0);
        advance();
        drive(4'b1010, 0, 0);
        checks++;
        if (grant_valid !== 1'b0 || locked !== 1'b1 || eff_grant !== 2'd0) begin
            errors++; $display("FAIL drop_hold: gv=%0b locked=%0b eff=%0d required 0 1 0", grant_valid, locked, eff_grant);
        end
        advance();
        drive(4'b1011, 1, 1);
        checks++;
        if (grant_valid !== 1'b1 || eff_grant !== 2'd0) begin
            errors++; $display("FAIL drop_reraise: gv=%0b eff=%0d required 1 0", grant_valid, eff_grant);
        end
        advance();
        exp_p = {2'd0, 2'd2, 2'd3, 2'd1};
        checks++;
        if (locked !== 1'b0 || priority_array !== exp_p) begin
            errors++; $display("FAIL drop_unlock: locked=%0b prio=%h required 0 %h", locked, priority_array, exp_p);
        end
    endtask

    task automatic test_reset_mid_lock();
        logic [N-1:0][1:0] exp_p;
        exp_p = {2'd3, 2'd2, 2'd1, 2'd0};
        drive(4'b1000, 1, 1);
        advance();
        drive(4'b0010, 1, 0);
        advance();
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (locked !== 1'b0 || priority_array !== exp_p || grant_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_lock: locked=%0b prio=%h gv=%0b required 0 %h 0", locked, priority_array, grant_valid, exp_p);
        end
        model_reset();
        grant_fire = 0;
        request_vec = 4'h0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        logic         f, l;
        int           wait_cnt[N];
        logic [3:0]   seen;
        logic [1:0]   owner;
        bit           in_pkt;
        r = 4'h0;
        in_pkt = 0;
        owner = 2'd0;
        for (int i = 0; i < int'(N); i++) wait_cnt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < int'(N); i++) if ($urandom_range(7) == 0) r[i] = ~r[i];
            request_vec = r;
            #0;
            model_expect();
            f = exp_gv && ($urandom_range(3) != 0);
            l = ($urandom_range(2) == 0);
            drive(r, f, l);
            checks++;
            if (grant_valid !== exp_gv || eff_grant !== exp_eff || locked !== 1'(m_locked)
                || priority_array !== model_packed()) begin
                errors++;
                $display("FAIL random_cycle%0d: gv=%0b eff=%0d locked=%0b prio=%h required %0b %0d %0b %h",
                         c, grant_valid, eff_grant, locked, priority_array, exp_gv, exp_eff, m_locked, model_packed());
            end
            seen = 4'h0;
            for (int i = 0; i < int'(N); i++) seen[priority_array[i]] = 1'b1;
            checks++;
            if (seen !== 4'hF) begin errors++; $display("FAIL random_permutation: got %h required f", priority_array); end
            if (locked) begin
                checks++;
                if (in_pkt && eff_grant !== owner) begin
                    errors++; $display("FAIL random_lock_owner: got %0d required %0d", eff_grant, owner);
                end
            end
            if (f && exp_gv) begin
                if (!m_locked && !l) begin in_pkt = 1; owner = exp_eff; end
                if (l) in_pkt = 0;
                for (int i = 0; i < int'(N); i++) begin
                    if (!r[i] || i == int'(exp_eff)) wait_cnt[i] = 0;
                    else if (l) begin
                        wait_cnt[i]++;
                        checks++;
                        if (wait_cnt[i] > 3) begin
                            errors++; $display("FAIL random_fairness: req%0d waited %0d packets required <=3", i, wait_cnt[i]);
                        end
                    end
                end
            end else begin
                for (int i = 0; i < int'(N); i++) if (!r[i]) wait_cnt[i] = 0;
            end
            advance();
        end
        drive(4'h0, 0, 0);
    endtask

    initial begin
        clk = 0;
        checks = 0;
        errors = 0;
        test_reset();
        test_rotate();
        test_lock();
        test_drop();
        test_reset_mid_lock();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
